port_arbiter: RTL



---
 rtl/port_arbiter.sv | 73 +++++++
 1 files changed

// File: rtl/port_arbiter.sv
// port_arbiter: credit-gated round-robin arbiter for one router output link, registered one-hot grant.
// Define PORT_ARBITER_LOCAL_PRIO_EN to give the local NI (index 0) absolute priority.
module port_arbiter #(
    parameter int N_REQ   = 5,
    parameter int CREDITS = 4
) (
    input  logic             i_clk,
    input  logic             i_srst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_creditReturn,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_valid,
    output logic             o_stall,
    output logic [3:0]       o_credits,
    output logic             o_creditErr
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d, pick;
    logic [3:0] credits_q, credits_d;
    logic [N_REQ-1:0] grant_q, grant_d, elig;
    logic valid_q, valid_d, err_q, err_d;
    logic has_cred, full, do_grant;
    assign has_cred = credits_q != 4'd0;
    assign full = credits_q == 4'(CREDITS);
    always_comb begin
        // the requester whose grant is on the link now is still holding i_req for that same packet
        elig = i_req & ~grant_q;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) if (elig[k]) pick = PW'(k);
        for (int k = N_REQ - 1; k >= 0; k--) if (elig[k] && k >= int'(rr_ptr_q)) pick = PW'(k);
        do_grant = has_cred && |elig;
        rr_ptr_d = do_grant ? ((pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1) : rr_ptr_q;
`ifdef PORT_ARBITER_LOCAL_PRIO_EN
        if (has_cred && i_req[0]) begin
            pick = '0;
            do_grant = 1'b1;
            rr_ptr_d = rr_ptr_q;
        end
`else
`endif
        grant_d = do_grant ? N_REQ'(1) << pick : '0;
        valid_d = do_grant;
        credits_d = (do_grant == i_creditReturn) ? credits_q :
                    do_grant ? credits_q - 4'd1 :
                    full ? credits_q : credits_q + 4'd1;
        err_d = i_creditReturn && !do_grant && full;
        state_d = !(|i_req) ? IDLE : has_cred ? ACTIVE : STALL;
    end
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            credits_q <= 4'(CREDITS);
            grant_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            credits_q <= credits_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            err_q <= err_d;
        end
    end
    assign o_grant = grant_q;
    assign o_valid = valid_q;
    assign o_stall = state_q == STALL;
    assign o_credits = credits_q;
    assign o_creditErr = err_q;
endmodule
